dds_uart_config: RTL

//  UART command receiver upstream of the DDS control path. Deserialises 8N1 frames from a host
//  and decodes them into the DDS operating set: phase step M, amplitude in mV, waveform shape.
//  Its outputs drive the phase accumulator tuning word and the amplitude/shape selects.

---
 rtl/dds_uart_config.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dds_uart_config.sv
// UART (8N1) command receiver for the DDS: deserialises host frames A5,CMD,DHI,DLO,CSUM and
// commits phase step, amplitude and waveform shape, flagging every rejected frame.
module dds_uart_config #(
  parameter int CLK_HZ  = 1000000,
  parameter int BAUD    = 9600,
  parameter int M_WIDTH = 15,
  parameter int A_WIDTH = 11,
  parameter int A_MAX   = 1650,
  parameter int M_RESET = 100,
  parameter int A_RESET = 1000,
  parameter int TIMEOUT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic [M_WIDTH-1:0] phase_M,
  output logic [A_WIDTH-1:0] signal_A,
  output logic [1:0]         signal_shape,
  output logic               update,
  output logic               frame_err
);

  localparam int BIT_DIV  = CLK_HZ / BAUD;
  localparam int HALF_DIV = BIT_DIV / 2;
  localparam int TO_CLKS  = TIMEOUT * BIT_DIV;
  localparam int CNT_W    = $clog2(BIT_DIV);
  localparam int TO_W     = $clog2(TO_CLKS + 1);
  localparam logic [7:0]  HDR_BYTE = 8'hA5;
  localparam logic [16:0] M_LIMIT  = 17'(2 ** M_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CSUM} parse_state_t;

  // ---------------------------------------------------------------- receiver
  logic             rx_meta, rx_sync, rx_prev, rx_fall;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_clr, sample, byte_valid, rx_ferr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_next    = rx_state;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    byte_valid = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_fall) rx_next = RX_START;
      end
      RX_START: if (bit_cnt == CNT_W'(HALF_DIV - 1)) begin
        cnt_clr = 1'b1;
        rx_next = rx_sync ? RX_IDLE : RX_DATA;  // line back high: glitch, not a start bit
      end
      RX_DATA: if (bit_cnt == CNT_W'(BIT_DIV - 1)) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (bit_cnt == CNT_W'(BIT_DIV - 1)) begin
        cnt_clr    = 1'b1;
        rx_next    = RX_IDLE;
        byte_valid = rx_sync;
        rx_ferr    = ~rx_sync;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rx_state <= rx_next;
      bit_cnt  <= cnt_clr ? '0 : bit_cnt + 1'b1;
      if (rx_state == RX_START) bit_idx <= '0;
      else if (sample)          bit_idx <= bit_idx + 1'b1;
      if (sample) shift <= {rx_sync, shift[7:1]};
    end
  end

  // ---------------------------------------------------------------- parser
  parse_state_t    p_state, p_next;
  logic [7:0]      cmd, dhi, dlo, cmd_n, dhi_n, dlo_n;
  logic [15:0]     d_val;
  logic [TO_W-1:0] idle_cnt;
  logic            timeout;
  logic [M_WIDTH-1:0] m_n;
  logic [A_WIDTH-1:0] a_n;
  logic [1:0]      sh_n;
  logic            upd_n, err_n;

  assign d_val   = {dhi, dlo};
  assign timeout = (p_state != P_HDR) && (idle_cnt == TO_W'(TO_CLKS));

  // Idle time counts only while mid-frame and the line is quiet between bytes.
  always_ff @(posedge clk) begin
    if (rst || p_state == P_HDR || rx_state != RX_IDLE || timeout) idle_cnt <= '0;
    else                                                          idle_cnt <= idle_cnt + 1'b1;
  end

  always_comb begin
    p_next = p_state;
    cmd_n  = cmd;
    dhi_n  = dhi;
    dlo_n  = dlo;
    m_n    = phase_M;
    a_n    = signal_A;
    sh_n   = signal_shape;
    upd_n  = 1'b0;
    err_n  = 1'b0;
    if (timeout) begin
      err_n  = 1'b1;
      p_next = (byte_valid && shift == HDR_BYTE) ? P_CMD : P_HDR;
    end else if (rx_ferr) begin
      if (p_state != P_HDR) begin
        err_n  = 1'b1;
        p_next = P_HDR;
      end
    end else if (byte_valid) begin
      case (p_state)
        P_HDR:  if (shift == HDR_BYTE) p_next = P_CMD;
        P_CMD:  begin cmd_n = shift; p_next = P_DHI; end
        P_DHI:  begin dhi_n = shift; p_next = P_DLO; end
        P_DLO:  begin dlo_n = shift; p_next = P_CSUM; end
        P_CSUM: begin
          p_next = P_HDR;
          err_n  = 1'b1;
          if (shift == (cmd ^ dhi ^ dlo)) begin
            case (cmd)
              8'h01: if (d_val != '0 && {1'b0, d_val} < M_LIMIT) begin
                m_n = d_val[M_WIDTH-1:0]; upd_n = 1'b1; err_n = 1'b0;
              end
              8'h02: if (d_val <= 16'(A_MAX)) begin
                a_n = d_val[A_WIDTH-1:0]; upd_n = 1'b1; err_n = 1'b0;
              end
              8'h03: if (d_val <= 16'd3) begin
                sh_n = d_val[1:0]; upd_n = 1'b1; err_n = 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: p_next = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state      <= P_HDR;
      cmd          <= '0;
      dhi          <= '0;
      dlo          <= '0;
      phase_M      <= M_WIDTH'(M_RESET);
      signal_A     <= A_WIDTH'(A_RESET);
      signal_shape <= 2'd0;
      update       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      p_state      <= p_next;
      cmd          <= cmd_n;
      dhi          <= dhi_n;
      dlo          <= dlo_n;
      phase_M      <= m_n;
      signal_A     <= a_n;
      signal_shape <= sh_n;
      update       <= upd_n;
      frame_err    <= err_n;
    end
  end

endmodule
